// File: rtl/register_file_loader.sv
// Host-side sequencer for the register file MAU port: turns host read/write/clear-all
// commands into timed mau_* strobes while the CPU is halted, and returns a one-cycle response.
//
//   state   | meaning
//   IDLE    | ready for a host command
//   READ    | mau read strobe, address driven
//   CAPTURE | sample registered rf_read_data
//   WRITE   | single-cycle mau write
//   CLEAR   | write CLEAR_VALUE to indices 0..31, one per cycle
//   RESP    | one-cycle response pulse
`timescale 1ns/1ps
module register_file_loader #(
  parameter logic [31:0] CLEAR_VALUE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        alive,
  input  logic        host_valid,
  output logic        host_ready,
  input  logic [1:0]  host_cmd,
  input  logic [4:0]  host_index,
  input  logic [31:0] host_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        resp_error,
  output logic        busy,
  output logic        mau_clk_en,
  output logic [31:0] mau_address,
  output logic [31:0] mau_data_write,
  output logic        mau_wren,
  input  logic [31:0] rf_read_data
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READ    = 3'd1,
    CAPTURE = 3'd2,
    WRITE   = 3'd3,
    CLEAR   = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_CLEAR = 2'b10;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [4:0]  cnt_inc;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  assign cnt_inc = cnt_q + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (host_valid) begin
          rdata_d = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          // Commands arriving while the CPU runs, or reserved ones, never touch the file.
          if (alive || (host_cmd == 2'b11)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else if (host_cmd == CMD_READ) begin
            addr_d  = {25'b0, host_index, 2'b00};
            state_d = READ;
          end else if (host_cmd == CMD_WRITE) begin
            addr_d  = {25'b0, host_index, 2'b00};
            wdata_d = host_wdata;
            state_d = WRITE;
          end else if (host_cmd == CMD_CLEAR) begin
            addr_d  = '0;
            wdata_d = CLEAR_VALUE;
            state_d = CLEAR;
          end
        end
      end
      READ:    state_d = alive ? RESP : CAPTURE;
      CAPTURE: begin
        state_d = RESP;
        if (!alive) rdata_d = rf_read_data;
      end
      WRITE:   state_d = RESP;
      CLEAR: begin
        if (!alive) begin
          cnt_d = cnt_inc;
          if (cnt_q == 5'd31) state_d = RESP;
          else                addr_d  = {25'b0, cnt_inc, 2'b00};
        end else begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Abort: the CPU came back while we owned the port.
    if (alive && (state_q == READ || state_q == CAPTURE ||
                  state_q == WRITE || state_q == CLEAR)) begin
      state_d = RESP;
      err_d   = 1'b1;
      rdata_d = '0;
    end
  end

  always_comb begin
    host_ready     = (state_q == IDLE) && !reset;
    busy           = (state_q != IDLE);
    resp_valid     = (state_q == RESP);
    resp_data      = resp_valid ? rdata_q : '0;
    resp_error     = resp_valid && err_q;
    mau_clk_en     = !alive && (state_q == READ || state_q == WRITE || state_q == CLEAR);
    mau_wren       = !alive && (state_q == WRITE || state_q == CLEAR);
    mau_address    = addr_q;
    mau_data_write = wdata_q;
  end

endmodule

// File: doc/register_file_loader.md
# register_file_loader

Host-side sequencer for the register file's MAU port. While the CPU is halted (`alive` = 0) it accepts single-register read, write and clear-all commands from the debug/host interface over a valid/ready handshake. It turns each command into timed `mau_*` strobes, captures the registered read data, and returns a one-cycle response. It sits directly upstream of the register file's MAU port and consumes the file's port-0 read data.

## Interface
- CLEAR_VALUE, 32'h0000_0000, data written to every register by the clear command
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- alive  in  1  CPU running; this block may drive the register file only when 0
- host_valid  in  1  command present
- host_ready  out  1  block can accept a command
- host_cmd  in  2  00 read, 01 write, 10 clear-all, 11 reserved
- host_index  in  5  register number
- host_wdata  in  32  write data
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  32  read data (0 for write, clear and error)
- resp_error  out  1  command rejected or aborted
- busy  out  1  command in progress (state ≠ IDLE)
- mau_clk_en  out  1  register-file clock enable
- mau_address  out  32  byte address {25'b0, index, 2'b00}
- mau_data_write  out  32  write data
- mau_wren  out  1  write enable
- rf_read_data  in  32  register-file port-0 read data (cpu_data_read1); valid one cycle after the address/clk_en cycle

## Operation
- States: IDLE, READ, CAPTURE, WRITE, CLEAR, RESP.
- IDLE:
  - host_ready = 1; all other states host_ready = 0.
  - Accept on host_valid & host_ready; latch cmd, index and wdata.
- Acceptance with alive = 1 or cmd = 11: go to RESP with error = 1. No mau activity.
- Read: IDLE → READ → CAPTURE → RESP.
  - READ drives address, mau_clk_en = 1, mau_wren = 0.
  - CAPTURE samples rf_read_data into resp_data.
- Write: IDLE → WRITE → RESP.
  - WRITE drives address, wdata, mau_clk_en = 1, mau_wren = 1 for exactly one cycle.
- Clear: IDLE → CLEAR → RESP.
  - A 5-bit counter starts at 0 and writes CLEAR_VALUE to indices 0..31, one per cycle (32 write cycles).
  - Leave CLEAR when the counter equals 31; the counter wraps to 0.
- RESP: resp_valid = 1 for one cycle, then return to IDLE. No backpressure on responses.
- Reading index 31 returns 0, because the register file forces r31 reads to 0. This block passes rf_read_data through unmodified.
- Abort: if alive rises in READ, CAPTURE, WRITE or CLEAR:
  - mau_clk_en and mau_wren drop in the same cycle (combinationally gated by ~alive).
  - Next state is RESP with error = 1 and resp_data = 0.
  - Registers already cleared stay cleared.
- mau_address and mau_data_write are registered. They hold their last value in IDLE. Their values are don't-care when mau_clk_en = 0.

## Timing
- Reset values:
  - state IDLE, host_ready 0 while reset is asserted and 1 from the first cycle after
  - resp_valid 0, resp_data 0, resp_error 0, busy 0
  - mau_clk_en 0, mau_wren 0, mau_address 0, mau_data_write 0
  - clear counter 0
- Command accepted at edge T:
  - Read: mau strobe in cycle T+1; rf_read_data sampled at the end of T+2; resp_valid in T+3.
  - Write: mau_wren in T+1; resp_valid in T+2.
  - Clear: writes in T+1..T+32; resp_valid in T+33.
  - Error (alive or reserved cmd): resp_valid in T+1.
  - Abort detected in cycle A: resp_valid in A+1.
- Back-to-back commands: the next command is accepted in the cycle after resp_valid (IDLE). Minimum write-to-write spacing is 3 cycles.
- Reset mid-operation: return to the reset state immediately. mau_wren is 0 asynchronously and no response is produced.

## Test plan
- alive = 0, write index 5 data 32'hDEAD_BEEF, then read index 5:
  - mau_wren high only in T+1, mau_address = 32'h14.
  - Read response at T+3 with resp_data = 32'hDEAD_BEEF, resp_error = 0.
- alive = 0, clear-all after writing 32'h1234_5678 to index 30:
  - 32 consecutive mau_wren cycles with addresses 0x00..0x7C.
  - Response at T+33; a subsequent read of index 30 returns 0.
- Read index 31 after a write of 32'hFFFF_FFFF to it → resp_data = 0.
- alive = 1 with a write command:
  - No mau_clk_en or mau_wren activity.
  - resp_valid at T+1 with resp_error = 1; host_ready back to 1 at T+2.
- Clear started, alive raised in the 10th write cycle:
  - mau_wren low in that same cycle; response with error at the next cycle.
  - Indices 0..8 read back as 0 after alive is dropped again; index 9 and up unchanged.
- reset asserted during CLEAR:
  - All outputs return to their reset values asynchronously; no resp_valid.
  - host_ready = 1 in the first cycle after reset deasserts.
